hv_pwm_intb_encode: RTL and testbench

HV-side scheduler for the single isolated return wire `pwm_intb_n`. The wire is shared between two requesters: the gate-wave mirror and the HV interrupt. In idle the block mirrors the gate wave onto the wire. When the HV interrupt level changes, it pre-empts the mirror and transmits a pulse burst: 1 pulse means interrupt asserted (low), 4 pulses mean interrupt released (high). The LV-side PWM/INTB decoder consumes this burst format.

---
 rtl/hv_pwm_intb_encode.sv | 134 +++++++++++++
 tb/tb_hv_pwm_intb_encode.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hv_pwm_intb_encode.sv
// Schedules the shared HV return wire: mirrors the gate wave when idle, and
// pre-empts it with a pulse burst (1 pulse = INTB asserted, 4 = released) on interrupt changes.
module hv_pwm_intb_encode #(
    parameter int PULSE_W = 6,
    parameter int GAP_W   = 6,
    parameter int PRE_W   = 12,
    parameter int END_W   = 12
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pwm_gwave,
    input  logic i_intb_n,
    output logic o_hv_pwm_intb_n,
    output logic o_busy,
    output logic o_sent_intb_n
);

    localparam int MAX_AB = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int MAX_CD = (PRE_W > END_W) ? PRE_W : END_W;
    localparam int MAX_W  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] PULSE_LEN = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] GAP_LEN   = CNT_W'(GAP_W);
    localparam logic [CNT_W-1:0] PRE_LEN   = CNT_W'(PRE_W);
    localparam logic [CNT_W-1:0] END_LEN   = CNT_W'(END_W);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_TAIL  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pcnt_q, pcnt_d;
    logic             sent_q, sent_d;
    logic             wire_q, wire_d;

    logic [2:0] pcnt_inc;
    logic [2:0] n_tgt;

    assign pcnt_inc = pcnt_q + 3'd1;
    assign n_tgt    = sent_q ? 3'd4 : 3'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            sent_q  <= 1'b1;
            wire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            sent_q  <= sent_d;
            wire_q  <= wire_d;
        end
    end

    // wire_d is the wire value for the state being entered, so the output
    // register always lines up with the registered state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        pcnt_d  = pcnt_q;
        sent_d  = sent_q;
        wire_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = cnt_q;
                wire_d = i_pwm_gwave;
                if (i_intb_n != sent_q) begin
                    state_d = ST_PRE;
                    cnt_d   = CNT_ONE;
                    pcnt_d  = 3'd0;
                    sent_d  = i_intb_n;
                    wire_d  = 1'b0;
                end
            end
            ST_PRE: begin
                if (cnt_q == PRE_LEN) begin
                    state_d = ST_PULSE;
                    cnt_d   = CNT_ONE;
                    wire_d  = 1'b1;
                end
            end
            ST_PULSE: begin
                wire_d = 1'b1;
                if (cnt_q == PULSE_LEN) begin
                    pcnt_d = pcnt_inc;
                    cnt_d  = CNT_ONE;
                    wire_d = 1'b0;
                    state_d = (pcnt_inc < n_tgt) ? ST_GAP : ST_TAIL;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LEN) begin
                    state_d = ST_PULSE;
                    cnt_d   = CNT_ONE;
                    wire_d  = 1'b1;
                end
            end
            ST_TAIL: begin
                if (cnt_q == END_LEN) begin
                    cnt_d = CNT_ONE;
                    // Only the level at tail exit matters; intermediate glitches are dropped.
                    if (i_intb_n != sent_q) begin
                        state_d = ST_PRE;
                        pcnt_d  = 3'd0;
                        sent_d  = i_intb_n;
                    end else begin
                        state_d = ST_IDLE;
                        wire_d  = i_pwm_gwave;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                wire_d  = 1'b0;
            end
        endcase
    end

    assign o_hv_pwm_intb_n = wire_q;
    assign o_busy          = (state_q != ST_IDLE);
    assign o_sent_intb_n   = sent_q;

endmodule

// File: tb/tb_hv_pwm_intb_encode.sv
// Self-checking bench: queue-based waveform model of the return wire, directed
// scenarios with literal timing checks, then a randomized soak.
module tb_hv_pwm_intb_encode;

    localparam int PULSE_W = 6;
    localparam int GAP_W   = 6;
    localparam int PRE_W   = 12;
    localparam int END_W   = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic gwave = 1'b0;
    logic intb_n = 1'b1;
    logic wire_o, busy_o, sent_o;

    hv_pwm_intb_encode #(
        .PULSE_W(PULSE_W), .GAP_W(GAP_W), .PRE_W(PRE_W), .END_W(END_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_pwm_gwave(gwave),
        .i_intb_n(intb_n),
        .o_hv_pwm_intb_n(wire_o),
        .o_busy(busy_o),
        .o_sent_intb_n(sent_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model: a burst is a precomputed list of wire values; the wire mirrors
    // the gate wave whenever that list is empty.
    bit m_q[$];
    bit m_wire = 1'b0;
    bit m_busy = 1'b0;
    bit m_sent = 1'b1;

    task automatic push_burst(input bit tgt);
        int n;
        n = tgt ? 4 : 1;
        repeat (PRE_W) m_q.push_back(1'b0);
        for (int p = 0; p < n; p++) begin
            repeat (PULSE_W) m_q.push_back(1'b1);
            if (p < n - 1) repeat (GAP_W) m_q.push_back(1'b0);
        end
        repeat (END_W) m_q.push_back(1'b0);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_q.delete();
            m_wire = 1'b0;
            m_busy = 1'b0;
            m_sent = 1'b1;
        end else begin
            if (m_q.size() == 0 && intb_n != m_sent) begin
                m_sent = intb_n;
                push_burst(intb_n);
            end
            if (m_q.size() != 0) begin
                m_wire = m_q.pop_front();
                m_busy = 1'b1;
            end else begin
                m_wire = gwave;
                m_busy = 1'b0;
            end
        end
    end

    bit log_w [0:255];
    bit log_b [0:255];
    bit log_s [0:255];
    int run_len  = 0;
    int last_run = 0;
    int busy_cnt = 0;

    always @(posedge clk) begin
        #1;
        chk("wire", int'(wire_o), int'(m_wire));
        chk("busy", int'(busy_o), int'(m_busy));
        chk("sent", int'(sent_o), int'(m_sent));
        if (cyc < 256) begin
            log_w[cyc] = wire_o;
            log_b[cyc] = busy_o;
            log_s[cyc] = sent_o;
        end
        if (busy_o) begin
            run_len++;
            busy_cnt++;
        end else begin
            if (run_len > 0) last_run = run_len;
            run_len = 0;
        end
    end

    task automatic run_toggle(input int n);
        repeat (n) begin
            @(negedge clk);
            gwave = ((cyc / 20) % 2) != 0;
        end
    endtask

    initial begin
        @(negedge clk);
        #1;
        chk("reset_wire", int'(wire_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_sent", int'(sent_o), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Mirror phase, then assert burst launched from cycle 100 with gwave high.
        while (cyc < 100) begin
            gwave = ((cyc / 20) % 2) != 0;
            @(negedge clk);
        end
        gwave  = ((cyc / 20) % 2) != 0;
        intb_n = 1'b0;
        run_toggle(40);
        chk("mirror_40", int'(log_w[40]), 1);
        chk("mirror_41", int'(log_w[41]), 0);
        chk("idle_busy_100", int'(log_b[100]), 0);
        chk("sent_100", int'(log_s[100]), 1);
        chk("pre_wire_101", int'(log_w[101]), 0);
        chk("busy_101", int'(log_b[101]), 1);
        chk("sent_101", int'(log_s[101]), 0);
        chk("pre_wire_112", int'(log_w[112]), 0);
        for (int c = 113; c <= 118; c++) chk("pulse_wire", int'(log_w[c]), 1);
        chk("tail_wire_119", int'(log_w[119]), 0);
        chk("busy_130", int'(log_b[130]), 1);
        chk("busy_131", int'(log_b[131]), 0);
        chk("assert_run", last_run, 30);

        // Release burst.
        intb_n = 1'b1;
        run_toggle(80);
        chk("release_run", last_run, 66);

        // Interrupt bounces back during the single pulse: back-to-back bursts.
        intb_n = 1'b0;
        run_toggle(14);
        intb_n = 1'b1;
        run_toggle(110);
        chk("chained_run", last_run, 96);

        // Glitch entirely within PRE of a release burst is swallowed.
        intb_n = 1'b0;
        run_toggle(40);
        intb_n = 1'b1;
        run_toggle(3);
        intb_n = 1'b0;
        run_toggle(3);
        intb_n = 1'b1;
        run_toggle(80);
        chk("glitch_run", last_run, 66);
        chk("glitch_sent", int'(sent_o), 1);

        // Reset during a GAP of a release burst.
        intb_n = 1'b0;
        run_toggle(40);
        intb_n = 1'b1;
        run_toggle(20);
        chk("gap_busy", int'(busy_o), 1);
        rst = 1'b1;
        #1;
        chk("async_wire", int'(wire_o), 0);
        chk("async_busy", int'(busy_o), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        busy_cnt = 0;
        run_toggle(60);
        chk("post_reset_busy_cycles", busy_cnt, 0);

        // Randomized soak.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            gwave = 1'($urandom);
            if ($urandom_range(0, 39) == 0) intb_n = ~intb_n;
            rst = ($urandom_range(0, 799) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
